// File: rtl/bbox_scanner_pkg.sv
// Shared types for the bounding-box scanner: frame size constants,
// coordinate width and the three-vertex triangle bundle.
package bbox_scanner_pkg;

    localparam int FRAME_W = 512;
    localparam int FRAME_H = 384;
    localparam int CRD_W   = 16;

    typedef struct packed {
        logic signed [CRD_W-1:0] x;
        logic signed [CRD_W-1:0] y;
    } vtx_t;

    // Vertex 0 occupies the low bits.
    typedef vtx_t [2:0] tri_2d;

endpackage

// File: rtl/bbox_scanner.sv
// Bounding-box scanner: accepts a triangle, clamps its bounding box to
// the frame and streams every pixel of that box in raster order.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   tri_valid/tri_ready    triangle handshake; tri_in vertices, col_in colour
//   out_valid/out_ready    pixel handshake; out_hcount/out_vcount coordinate
//   out_tri/out_col        triangle and colour held for the whole scan
//   out_last               final pixel of the triangle
//   busy                   high whenever not idle
//
// Build option: define BBOX_SCANNER_CULL_EN to add a one-cycle AREA
// state that drops zero-area (degenerate) triangles.
module bbox_scanner
    import bbox_scanner_pkg::*;
#(
    parameter int FRAME_WIDTH  = FRAME_W,
    parameter int FRAME_HEIGHT = FRAME_H,
    parameter int COORD_BITS   = CRD_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tri_valid,
    output logic                         tri_ready,
    input  tri_2d                        tri_in,
    input  logic [15:0]                  col_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [COORD_BITS-1:0] out_hcount,
    output logic signed [COORD_BITS-1:0] out_vcount,
    output tri_2d                        out_tri,
    output logic [15:0]                  out_col,
    output logic                         out_last,
    output logic                         busy
);

    typedef logic signed [COORD_BITS-1:0] crd_t;

`ifdef BBOX_SCANNER_CULL_EN
    typedef enum logic [1:0] {IDLE, SETUP, SCAN, AREA} state_t;
`else
    typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;
`endif

    localparam crd_t XLIM = crd_t'(FRAME_WIDTH - 1);
    localparam crd_t YLIM = crd_t'(FRAME_HEIGHT - 1);

    function automatic crd_t smin(crd_t a, crd_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic crd_t smax(crd_t a, crd_t b);
        return (a > b) ? a : b;
    endfunction

    // Clamped low edge of the box along one axis.
    function automatic crd_t lo3(crd_t a, crd_t b, crd_t c);
        return smax(crd_t'(0), smin(smin(a, b), c));
    endfunction

    // Clamped high edge of the box along one axis.
    function automatic crd_t hi3(crd_t a, crd_t b, crd_t c, crd_t lim);
        return smin(lim, smax(smax(a, b), c));
    endfunction

    state_t state, state_nxt;

    tri_2d       tri_q;
    logic [15:0] col_q;
    crd_t        hcount, vcount;
    crd_t        xmin, xmax, ymin, ymax;

    crd_t bx_lo, bx_hi, by_lo, by_hi;
    logic box_empty;
    logic at_end;

    assign bx_lo = lo3(tri_q[0].x, tri_q[1].x, tri_q[2].x);
    assign bx_hi = hi3(tri_q[0].x, tri_q[1].x, tri_q[2].x, XLIM);
    assign by_lo = lo3(tri_q[0].y, tri_q[1].y, tri_q[2].y);
    assign by_hi = hi3(tri_q[0].y, tri_q[1].y, tri_q[2].y, YLIM);

    assign box_empty = (bx_hi < bx_lo) || (by_hi < by_lo);
    assign at_end    = (hcount == xmax) && (vcount == ymax);

`ifdef BBOX_SCANNER_CULL_EN
    localparam int AW = 2 * COORD_BITS + 1;
    typedef logic signed [AW-1:0] wide_t;

    wide_t area;

    // Twice the signed triangle area; zero means collinear vertices.
    always_comb begin
        area = (wide_t'(tri_q[1].x) - wide_t'(tri_q[0].x))
             * (wide_t'(tri_q[2].y) - wide_t'(tri_q[0].y))
             - (wide_t'(tri_q[2].x) - wide_t'(tri_q[0].x))
             * (wide_t'(tri_q[1].y) - wide_t'(tri_q[0].y));
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tri_ready = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy      = 1'b0;
                tri_ready = 1'b1;
                if (tri_valid) begin
`ifdef BBOX_SCANNER_CULL_EN
                    state_nxt = AREA;
`else
                    state_nxt = SETUP;
`endif
                end
            end
`ifdef BBOX_SCANNER_CULL_EN
            AREA: begin
                state_nxt = (area == '0) ? IDLE : SETUP;
            end
`endif
            SETUP: begin
                state_nxt = box_empty ? IDLE : SCAN;
            end
            SCAN: begin
                out_valid = 1'b1;
                out_last  = at_end;
                if (out_ready && at_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // The state register only clears at the edge, so outputs are
        // masked for the whole reset cycle.
        if (rst) begin
            tri_ready = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
            busy      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tri_q  <= '0;
            col_q  <= '0;
            hcount <= '0;
            vcount <= '0;
            xmin   <= '0;
            xmax   <= '0;
            ymin   <= '0;
            ymax   <= '0;
        end else begin
            if (state == IDLE && tri_valid) begin
                tri_q <= tri_in;
                col_q <= col_in;
            end
            if (state == SETUP) begin
                xmin   <= bx_lo;
                xmax   <= bx_hi;
                ymin   <= by_lo;
                ymax   <= by_hi;
                hcount <= bx_lo;
                vcount <= by_lo;
            end
            if (state == SCAN && out_ready && !at_end) begin
                if (hcount == xmax) begin
                    hcount <= xmin;
                    vcount <= vcount + crd_t'(1);
                end else begin
                    hcount <= hcount + crd_t'(1);
                end
            end
        end
    end

    assign out_hcount = hcount;
    assign out_vcount = vcount;
    assign out_tri    = tri_q;
    assign out_col    = col_q;

endmodule
